axis_packetizer: RTL and testbench

AXIS_PACKETIZER -- requirements
Module: axis_packetizer

---
 rtl/axis_packetizer_pkg.sv | 15 +
 rtl/axis_packetizer.sv | 175 +++++++++++++++++
 tb/tb_axis_packetizer.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_packetizer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axis_packetizer_pkg
//  Description : Shared defaults for the AXI-Stream packetizer slice.
//                DEF_DATA_WIDTH - default stream data width in bits
//                DEF_CNTR_WIDTH - default packet-length / status counter width
//  Revision    : 1.0 - initial release
// ============================================================================
package axis_packetizer_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_CNTR_WIDTH = 32;

endpackage : axis_packetizer_pkg
`default_nettype wire

// File: rtl/axis_packetizer.sv
`default_nettype none
// ============================================================================
//  Module      : axis_packetizer
//  Description : Cuts a continuous AXI-Stream into packets of cfg_data beats,
//                marking the final beat of each packet with tlast. Either one
//                packet per arm (CONTINUOUS=0) or back-to-back packets
//                (CONTINUOUS=1). Single output register stage, latency 1.
//
//  Ports
//    aclk           in   clock, rising edge
//    aresetn        in   synchronous active-low reset
//    cfg_data       in   packet length in beats, 0 = disarmed
//    sts_data       out  number of completed packets (tlast handshakes)
//    s_axis_tdata   in   upstream data
//    s_axis_tvalid  in   upstream valid
//    s_axis_tready  out  upstream ready
//    m_axis_tdata   out  downstream data
//    m_axis_tvalid  out  downstream valid
//    m_axis_tready  in   downstream ready
//    m_axis_tlast   out  downstream last-beat marker
//
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_packetizer
    import axis_packetizer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNTR_WIDTH = DEF_CNTR_WIDTH,
    parameter int CONTINUOUS = 0
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [CNTR_WIDTH-1:0] cfg_data,
    output logic [CNTR_WIDTH-1:0] sts_data,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [CNTR_WIDTH-1:0] c_CNT_ONE = CNTR_WIDTH'(1);

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic [CNTR_WIDTH-1:0] len_q;
    logic [CNTR_WIDTH-1:0] len_d;
    logic [CNTR_WIDTH-1:0] cnt_q;
    logic [CNTR_WIDTH-1:0] cnt_d;
    logic [CNTR_WIDTH-1:0] sts_q;
    logic [DATA_WIDTH-1:0] tdata_q;
    logic                  tvalid_q;
    logic                  tlast_q;

    logic                  w_out_ready;
    logic                  w_tready;
    logic                  w_accept;
    logic                  w_last_beat;
    logic                  w_cfg_zero;

    // The output register can take a new beat when it is empty or being drained.
    assign w_out_ready = ~tvalid_q | m_axis_tready;
    assign w_accept    = s_axis_tvalid & w_tready;
    // Only meaningful in RUN, where len_q is always at least 1.
    assign w_last_beat = (cnt_q == (len_q - c_CNT_ONE));
    assign w_cfg_zero  = (cfg_data == '0);

    // ------------------------------------------------------------------------
    // State register (with length and beat counter)
    // ------------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= c_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        case (state_q)
            c_IDLE: begin
                if (!w_cfg_zero) begin
                    state_d = c_RUN;
                    len_d   = cfg_data;
                end
            end
            c_RUN: begin
                // cfg_data is only sampled at a packet boundary, so changes
                // mid-packet wait for the current packet to finish.
                if (w_accept) begin
                    if (w_last_beat) begin
                        cnt_d = '0;
                        if (CONTINUOUS != 0) begin
                            len_d = cfg_data;
                            if (w_cfg_zero) begin
                                state_d = c_IDLE;
                            end
                        end else begin
                            state_d = c_DONE;
                        end
                    end else begin
                        cnt_d = cnt_q + c_CNT_ONE;
                    end
                end
            end
            c_DONE: begin
                // Re-arming needs cfg_data to pass through zero first.
                if (w_cfg_zero) begin
                    state_d = c_IDLE;
                end
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_tready = (state_q == c_RUN) & w_out_ready;
    end

    assign s_axis_tready = w_tready;

    // Output stage control: valid/last reset, data deliberately not reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else if (w_out_ready) begin
            tvalid_q <= w_accept;
            tlast_q  <= w_accept & w_last_beat;
        end
    end

    always_ff @(posedge aclk) begin
        if (w_out_ready) begin
            tdata_q <= s_axis_tdata;
        end
    end

    // Completed-packet counter; wraps naturally at 2^CNTR_WIDTH.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            sts_q <= '0;
        end else if (tvalid_q & m_axis_tready & tlast_q) begin
            sts_q <= sts_q + c_CNT_ONE;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign sts_data      = sts_q;

endmodule : axis_packetizer
`default_nettype wire

// File: tb/tb_axis_packetizer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_axis_packetizer
//  Description : Self-checking bench for axis_packetizer. Instance 0 is the
//                one-shot variant, instance 1 the continuous variant. Beats
//                are offered from per-instance queues; accepted and delivered
//                beats are logged and compared with expectations derived from
//                the packet-length rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_packetizer;

    localparam int DW = 32;
    localparam int CW = 32;

    typedef logic [31:0] q_t  [$];
    typedef bit          bq_t [$];
    typedef int          iq_t [$];

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [CW-1:0] cfg      [2];
    logic [CW-1:0] sts      [2];
    logic [DW-1:0] s_tdata  [2];
    logic [DW-1:0] m_tdata  [2];
    logic [1:0]    s_tvalid;
    logic [1:0]    s_tready;
    logic [1:0]    m_tvalid;
    logic [1:0]    m_tready;
    logic [1:0]    m_tlast;

    q_t  src      [2];
    q_t  acc_data [2];
    q_t  acc_cfg  [2];
    q_t  out_data [2];
    bq_t out_last [2];
    iq_t out_cyc  [2];
    int  p_valid  [2];
    int  p_ready  [2];
    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;

    always #5 aclk = ~aclk;

    axis_packetizer #(.DATA_WIDTH(DW), .CNTR_WIDTH(CW), .CONTINUOUS(0)) u_oneshot (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .cfg_data      (cfg[0]),
        .sts_data      (sts[0]),
        .s_axis_tdata  (s_tdata[0]),
        .s_axis_tvalid (s_tvalid[0]),
        .s_axis_tready (s_tready[0]),
        .m_axis_tdata  (m_tdata[0]),
        .m_axis_tvalid (m_tvalid[0]),
        .m_axis_tready (m_tready[0]),
        .m_axis_tlast  (m_tlast[0])
    );

    axis_packetizer #(.DATA_WIDTH(DW), .CNTR_WIDTH(CW), .CONTINUOUS(1)) u_cont (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .cfg_data      (cfg[1]),
        .sts_data      (sts[1]),
        .s_axis_tdata  (s_tdata[1]),
        .s_axis_tvalid (s_tvalid[1]),
        .s_axis_tready (s_tready[1]),
        .m_axis_tdata  (m_tdata[1]),
        .m_axis_tvalid (m_tvalid[1]),
        .m_axis_tready (m_tready[1]),
        .m_axis_tlast  (m_tlast[1])
    );

    // One clock cycle: log handshakes that the coming edge completes, then
    // drive fresh inputs on the falling edge.
    task automatic step();
        bit acc [2];
        for (int i = 0; i < 2; i++) begin
            acc[i] = 1'b0;
            if (aresetn) begin
                if (s_tvalid[i] && s_tready[i]) begin
                    acc_data[i].push_back(src[i].pop_front());
                    acc_cfg[i].push_back(cfg[i]);
                    acc[i] = 1'b1;
                end
                if (m_tvalid[i] && m_tready[i]) begin
                    out_data[i].push_back(m_tdata[i]);
                    out_last[i].push_back(m_tlast[i]);
                    out_cyc[i].push_back(cyc);
                end
            end
        end
        @(negedge aclk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (src[i].size() != 0 && s_tvalid[i] && !acc[i]) begin
                s_tdata[i] = src[i][0];
            end else if (src[i].size() != 0 && ($urandom_range(99) < p_valid[i])) begin
                s_tvalid[i] = 1'b1;
                s_tdata[i]  = src[i][0];
            end else begin
                s_tvalid[i] = 1'b0;
                s_tdata[i]  = $urandom;
            end
            m_tready[i] = ($urandom_range(99) < p_ready[i]);
        end
        #1;
    endtask

    task automatic clear_q();
        for (int i = 0; i < 2; i++) begin
            src[i].delete();
            acc_data[i].delete();
            acc_cfg[i].delete();
            out_data[i].delete();
            out_last[i].delete();
            out_cyc[i].delete();
            s_tvalid[i] = 1'b0;
            p_valid[i]  = 100;
            p_ready[i]  = 100;
        end
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        cfg[0]  = '0;
        cfg[1]  = '0;
        clear_q();
        step();
        step();
        aresetn = 1'b1;
        clear_q();
    endtask

    task automatic drain(input int i, input int budget, output bit ok);
        ok = 1'b0;
        p_valid[i] = 100;
        p_ready[i] = 100;
        for (int n = 0; n < budget; n++) begin
            step();
            if (src[i].size() == 0 && !m_tvalid[i] && !s_tvalid[i]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        cfg[0]  = 4;
        cfg[1]  = 4;
        clear_q();
        src[0].push_back(32'hA5);
        src[1].push_back(32'h5A);
        step();
        step();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (m_tvalid[i] !== 1'b0) begin failures++; $display("FAIL reset_tvalid[%0d]: got %b expected 0", i, m_tvalid[i]); end
            checks++;
            if (m_tlast[i] !== 1'b0) begin failures++; $display("FAIL reset_tlast[%0d]: got %b expected 0", i, m_tlast[i]); end
            checks++;
            if (sts[i] !== '0) begin failures++; $display("FAIL reset_sts[%0d]: got %0d expected 0", i, sts[i]); end
            checks++;
            if (s_tready[i] !== 1'b0) begin failures++; $display("FAIL reset_tready[%0d]: got %b expected 0", i, s_tready[i]); end
        end
        aresetn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (s_tready[i] !== 1'b0) begin failures++; $display("FAIL post_reset_tready[%0d]: got %b expected 0", i, s_tready[i]); end
        end
        step();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (s_tready[i] !== 1'b1) begin failures++; $display("FAIL armed_tready[%0d]: got %b expected 1", i, s_tready[i]); end
        end
    endtask

    task automatic test_oneshot();
        do_reset();
        cfg[0] = 4;
        for (int v = 1; v <= 6; v++) src[0].push_back(v);
        repeat (12) step();
        checks++;
        if (out_data[0].size() != 4) begin failures++; $display("FAIL oneshot_count: got %0d expected 4", out_data[0].size()); end
        for (int k = 0; k < 4 && k < out_data[0].size(); k++) begin
            checks++;
            if (out_data[0][k] !== 32'(k + 1) || out_last[0][k] !== (k == 3)) begin
                failures++;
                $display("FAIL oneshot_beat%0d: got data %0d last %b expected data %0d last %b",
                         k, out_data[0][k], out_last[0][k], k + 1, (k == 3));
            end
        end
        checks++;
        if (s_tready[0] !== 1'b0) begin failures++; $display("FAIL oneshot_done_tready: got %b expected 0", s_tready[0]); end
        checks++;
        if (sts[0] !== 1) begin failures++; $display("FAIL oneshot_sts: got %0d expected 1", sts[0]); end
        checks++;
        if (src[0].size() != 2) begin failures++; $display("FAIL oneshot_leftover: got %0d expected 2", src[0].size()); end
        // re-arm: zero, then a new length of 2 carries the two leftover beats
        cfg[0] = 0;
        repeat (2) step();
        cfg[0] = 2;
        repeat (8) step();
        checks++;
        if (out_data[0].size() != 6) begin
            failures++; $display("FAIL rearm_count: got %0d expected 6", out_data[0].size());
        end else begin
            checks++;
            if (out_data[0][4] !== 5 || out_data[0][5] !== 6 || out_last[0][4] !== 1'b0 || out_last[0][5] !== 1'b1) begin
                failures++;
                $display("FAIL rearm_beats: got %0d/%b %0d/%b expected 5/0 6/1",
                         out_data[0][4], out_last[0][4], out_data[0][5], out_last[0][5]);
            end
        end
        checks++;
        if (sts[0] !== 2) begin failures++; $display("FAIL rearm_sts: got %0d expected 2", sts[0]); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d [9];
        do_reset();
        cfg[1] = 3;
        for (int k = 0; k < 9; k++) begin exp_d[k] = $urandom; src[1].push_back(exp_d[k]); end
        repeat (16) step();
        checks++;
        if (out_data[1].size() != 9) begin failures++; $display("FAIL b2b_count: got %0d expected 9", out_data[1].size()); end
        for (int k = 0; k < 9 && k < out_data[1].size(); k++) begin
            checks++;
            if (out_data[1][k] !== exp_d[k] || out_last[1][k] !== ((k % 3) == 2) || out_cyc[1][k] != out_cyc[1][0] + k) begin
                failures++;
                $display("FAIL b2b_beat%0d: got data %h last %b cycle +%0d expected data %h last %b cycle +%0d",
                         k, out_data[1][k], out_last[1][k], out_cyc[1][k] - out_cyc[1][0], exp_d[k], ((k % 3) == 2), k);
            end
        end
        checks++;
        if (sts[1] !== 3) begin failures++; $display("FAIL b2b_sts: got %0d expected 3", sts[1]); end
    endtask

    task automatic test_stall();
        logic [31:0] exp_d [6];
        int          rdy [14] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        bit          was_stalled = 1'b0;
        logic [31:0] held = '0;
        do_reset();
        cfg[0] = 6;
        for (int k = 0; k < 6; k++) begin exp_d[k] = $urandom; src[0].push_back(exp_d[k]); end
        for (int k = 0; k < 14; k++) begin
            p_ready[0] = rdy[k] * 100;
            step();
            if (m_tvalid[0] && !m_tready[0]) begin
                checks++;
                if (s_tready[0] !== 1'b0) begin failures++; $display("FAIL stall_tready cyc%0d: got %b expected 0", k, s_tready[0]); end
                if (was_stalled) begin
                    checks++;
                    if (m_tdata[0] !== held) begin failures++; $display("FAIL stall_hold cyc%0d: got %h expected %h", k, m_tdata[0], held); end
                end
                was_stalled = 1'b1;
                held = m_tdata[0];
            end else begin
                was_stalled = 1'b0;
            end
        end
        checks++;
        if (out_data[0].size() != 6) begin failures++; $display("FAIL stall_count: got %0d expected 6", out_data[0].size()); end
        for (int k = 0; k < 6 && k < out_data[0].size(); k++) begin
            checks++;
            if (out_data[0][k] !== exp_d[k] || out_last[0][k] !== (k == 5)) begin
                failures++;
                $display("FAIL stall_beat%0d: got %h/%b expected %h/%b", k, out_data[0][k], out_last[0][k], exp_d[k], (k == 5));
            end
        end
        checks++;
        if (sts[0] !== 1) begin failures++; $display("FAIL stall_sts: got %0d expected 1", sts[0]); end
    endtask

    task automatic test_cfg_change();
        do_reset();
        cfg[1] = 4;
        for (int k = 0; k < 6; k++) src[1].push_back(100 + k);
        repeat (3) step();
        cfg[1] = 2;
        repeat (12) step();
        checks++;
        if (out_data[1].size() != 6) begin failures++; $display("FAIL cfgchg_count: got %0d expected 6", out_data[1].size()); end
        for (int k = 0; k < 6 && k < out_data[1].size(); k++) begin
            checks++;
            if (out_data[1][k] !== 32'(100 + k) || out_last[1][k] !== (k == 3 || k == 5)) begin
                failures++;
                $display("FAIL cfgchg_beat%0d: got %0d/%b expected %0d/%b", k, out_data[1][k], out_last[1][k], 100 + k, (k == 3 || k == 5));
            end
        end
        checks++;
        if (sts[1] !== 2) begin failures++; $display("FAIL cfgchg_sts: got %0d expected 2", sts[1]); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp_d [4];
        int          n;
        do_reset();
        cfg[0] = 4;
        for (int k = 0; k < 4; k++) src[0].push_back($urandom);
        for (n = 0; n < 20 && acc_data[0].size() < 2; n++) step();
        checks++;
        if (acc_data[0].size() != 2) begin failures++; $display("FAIL midrst_setup: got %0d accepted expected 2", acc_data[0].size()); end
        aresetn = 1'b0;
        step();
        aresetn = 1'b1;
        checks++;
        if (m_tvalid[0] !== 1'b0 || m_tlast[0] !== 1'b0) begin
            failures++; $display("FAIL midrst_out: got valid %b last %b expected 0 0", m_tvalid[0], m_tlast[0]);
        end
        checks++;
        if (sts[0] !== 0) begin failures++; $display("FAIL midrst_sts: got %0d expected 0", sts[0]); end
        clear_q();
        for (int k = 0; k < 4; k++) begin exp_d[k] = $urandom; src[0].push_back(exp_d[k]); end
        repeat (10) step();
        checks++;
        if (out_data[0].size() != 4) begin failures++; $display("FAIL midrst_count: got %0d expected 4", out_data[0].size()); end
        for (int k = 0; k < 4 && k < out_data[0].size(); k++) begin
            checks++;
            if (out_data[0][k] !== exp_d[k] || out_last[0][k] !== (k == 3)) begin
                failures++;
                $display("FAIL midrst_beat%0d: got %h/%b expected %h/%b", k, out_data[0][k], out_last[0][k], exp_d[k], (k == 3));
            end
        end
        checks++;
        if (sts[0] !== 1) begin failures++; $display("FAIL midrst_sts_after: got %0d expected 1", sts[0]); end
    endtask

    task automatic test_len1();
        logic [31:0] exp_d [10];
        bit          ok;
        do_reset();
        cfg[1] = 1;
        for (int k = 0; k < 10; k++) begin exp_d[k] = $urandom; src[1].push_back(exp_d[k]); end
        p_valid[1] = 70;
        p_ready[1] = 70;
        repeat (20) step();
        drain(1, 200, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL len1_drain: got timeout expected drained"); end
        checks++;
        if (out_data[1].size() != 10) begin failures++; $display("FAIL len1_count: got %0d expected 10", out_data[1].size()); end
        for (int k = 0; k < 10 && k < out_data[1].size(); k++) begin
            checks++;
            if (out_data[1][k] !== exp_d[k] || out_last[1][k] !== 1'b1) begin
                failures++; $display("FAIL len1_beat%0d: got %h/%b expected %h/1", k, out_data[1][k], out_last[1][k], exp_d[k]);
            end
        end
        checks++;
        if (sts[1] !== 10) begin failures++; $display("FAIL len1_sts: got %0d expected 10", sts[1]); end
    endtask

    // Random valid/ready/length changes on the continuous variant. Expected
    // tlast positions come from walking the accepted beats: a packet closes
    // after L beats and the next L is whatever cfg held when it closed.
    task automatic test_random();
        logic [31:0] exp_d [40];
        int          len;
        int          idx;
        int          nlast;
        bit          exp_last;
        bit          ok;
        do_reset();
        len    = $urandom_range(5, 1);
        cfg[1] = len;
        for (int k = 0; k < 40; k++) begin exp_d[k] = $urandom; src[1].push_back(exp_d[k]); end
        p_valid[1] = 60;
        p_ready[1] = 60;
        repeat (2) step();
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(99) < 20) cfg[1] = $urandom_range(5, 1);
            step();
        end
        drain(1, 300, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL rand_drain: got timeout expected drained"); end
        checks++;
        if (out_data[1].size() != 40 || acc_data[1].size() != 40) begin
            failures++; $display("FAIL rand_count: got out %0d acc %0d expected 40 40", out_data[1].size(), acc_data[1].size());
        end
        idx   = 0;
        nlast = 0;
        for (int k = 0; k < 40 && k < out_data[1].size() && k < acc_cfg[1].size(); k++) begin
            exp_last = (idx == len - 1);
            if (exp_last) begin
                nlast++;
                len = int'(acc_cfg[1][k]);
                idx = 0;
            end else begin
                idx++;
            end
            checks++;
            if (out_data[1][k] !== exp_d[k] || out_last[1][k] !== exp_last) begin
                failures++;
                $display("FAIL rand_beat%0d: got %h/%b expected %h/%b", k, out_data[1][k], out_last[1][k], exp_d[k], exp_last);
            end
        end
        checks++;
        if (sts[1] !== CW'(nlast)) begin failures++; $display("FAIL rand_sts: got %0d expected %0d", sts[1], nlast); end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            cfg[i]      = '0;
            s_tdata[i]  = '0;
            s_tvalid[i] = 1'b0;
            m_tready[i] = 1'b0;
            p_valid[i]  = 100;
            p_ready[i]  = 100;
        end
        test_reset();
        test_oneshot();
        test_back_to_back();
        test_stall();
        test_cfg_change();
        test_reset_mid();
        test_len1();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

endmodule : tb_axis_packetizer
`default_nettype wire
